// File: rtl/hash_msg_feeder.sv
// hash_msg_feeder
//   Buffers one host message (up to DEPTH bytes) and replays it to a hash core
//   as one gap-free burst, waits for the core's done pulse (bounded by TIMEOUT
//   cycles), and presents the digest with a valid/ready handshake.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_data/in_valid/in_last       host byte stream, in_ready = accept
//   core_M/core_M_valid/core_len   byte burst and length to the hash core
//   core_hash_ready/core_digest    one-cycle done pulse and digest from the core
//   dig_valid/dig_ready            result handshake to the consumer
//   dig_out/dig_len/dig_ovf/dig_err  digest, hashed length, truncation, timeout
module hash_msg_feeder #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic [7:0]               core_M,
    output logic                     core_M_valid,
    output logic [63:0]              core_len,
    input  logic                     core_hash_ready,
    input  logic [31:0]              core_digest,
    output logic                     dig_valid,
    input  logic                     dig_ready,
    output logic [31:0]              dig_out,
    output logic [$clog2(DEPTH):0]   dig_len,
    output logic                     dig_ovf,
    output logic                     dig_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_STREAM,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wcnt_q, wcnt_d;
    logic [LW-1:0]   len_q, len_d;
    logic            ovf_q, ovf_d;
    logic [LW-1:0]   scnt_q, scnt_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            in_ready_q, in_ready_d;
    logic [7:0]      core_m_q, core_m_d;
    logic            core_m_valid_q, core_m_valid_d;
    logic [63:0]     core_len_q, core_len_d;
    logic            dig_valid_q, dig_valid_d;
    logic [31:0]     dig_out_q, dig_out_d;
    logic [LW-1:0]   dig_len_q, dig_len_d;
    logic            dig_ovf_q, dig_ovf_d;
    logic            dig_err_q, dig_err_d;

    logic [7:0]      mem [DEPTH];
    logic            accept;
    logic            wr_en;
    logic [LW-1:0]   len_new;

    assign accept  = in_valid && in_ready_q;
    assign len_new = LW'(wcnt_q) + LW'(1);

    // Message buffer; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wcnt_q] <= in_data;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d        = state_q;
        wcnt_d         = wcnt_q;
        len_d          = len_q;
        ovf_d          = ovf_q;
        scnt_d         = scnt_q;
        tcnt_d         = tcnt_q;
        core_m_d       = core_m_q;
        core_m_valid_d = 1'b0;
        core_len_d     = core_len_q;
        dig_valid_d    = dig_valid_q;
        dig_out_d      = dig_out_q;
        dig_len_d      = dig_len_q;
        dig_ovf_d      = dig_ovf_q;
        dig_err_d      = dig_err_q;
        wr_en          = 1'b0;

        unique case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (in_last || (wcnt_q == AW'(DEPTH - 1))) begin
                        // A full buffer without in_last truncates the message.
                        ovf_d          = !in_last;
                        len_d          = len_new;
                        wcnt_d         = '0;
                        // Preload byte 0 so it is on the port in the first
                        // STREAM cycle; bypass when it is being written now.
                        core_m_d       = (wcnt_q == '0) ? in_data : mem[0];
                        core_m_valid_d = 1'b1;
                        core_len_d     = 64'(len_new);
                        scnt_d         = LW'(1);
                        state_d        = ST_STREAM;
                    end else begin
                        wcnt_d = wcnt_q + AW'(1);
                    end
                end
            end

            ST_STREAM: begin
                // scnt counts bytes already on the port, including this one.
                if (scnt_q == len_q) begin
                    core_m_d = '0;
                    tcnt_d   = '0;
                    state_d  = ST_WAIT;
                end else begin
                    core_m_d       = mem[scnt_q[AW-1:0]];
                    core_m_valid_d = 1'b1;
                    scnt_d         = scnt_q + LW'(1);
                end
            end

            ST_WAIT: begin
                if (core_hash_ready) begin
                    dig_out_d   = core_digest;
                    dig_err_d   = 1'b0;
                    dig_len_d   = len_q;
                    dig_ovf_d   = ovf_q;
                    dig_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    dig_out_d   = '0;
                    dig_err_d   = 1'b1;
                    dig_len_d   = len_q;
                    dig_ovf_d   = ovf_q;
                    dig_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end

            ST_OUT: begin
                if (dig_ready) begin
                    dig_valid_d = 1'b0;
                    wcnt_d      = '0;
                    ovf_d       = 1'b0;
                    state_d     = ST_LOAD;
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase

        // Registered ready tracks the state we are about to be in.
        in_ready_d = (state_d == ST_LOAD);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_LOAD;
            wcnt_q         <= '0;
            len_q          <= '0;
            ovf_q          <= 1'b0;
            scnt_q         <= '0;
            tcnt_q         <= '0;
            in_ready_q     <= 1'b0;
            core_m_q       <= '0;
            core_m_valid_q <= 1'b0;
            core_len_q     <= '0;
            dig_valid_q    <= 1'b0;
            dig_out_q      <= '0;
            dig_len_q      <= '0;
            dig_ovf_q      <= 1'b0;
            dig_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            wcnt_q         <= wcnt_d;
            len_q          <= len_d;
            ovf_q          <= ovf_d;
            scnt_q         <= scnt_d;
            tcnt_q         <= tcnt_d;
            in_ready_q     <= in_ready_d;
            core_m_q       <= core_m_d;
            core_m_valid_q <= core_m_valid_d;
            core_len_q     <= core_len_d;
            dig_valid_q    <= dig_valid_d;
            dig_out_q      <= dig_out_d;
            dig_len_q      <= dig_len_d;
            dig_ovf_q      <= dig_ovf_d;
            dig_err_q      <= dig_err_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign core_M       = core_m_q;
    assign core_M_valid = core_m_valid_q;
    assign core_len     = core_len_q;
    assign dig_valid    = dig_valid_q;
    assign dig_out      = dig_out_q;
    assign dig_len      = dig_len_q;
    assign dig_ovf      = dig_ovf_q;
    assign dig_err      = dig_err_q;

endmodule

// File: tb/tb_hash_msg_feeder.sv
// tb_hash_msg_feeder
//   Directed bench for hash_msg_feeder (DEPTH=8, TIMEOUT=16). A small core
//   model packs the last four streamed bytes into a word, XORs 0x5A000000 and
//   answers three cycles after the burst ends, so digests are easy to derive
//   by hand.
module tb_hash_msg_feeder;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned LW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [7:0]    core_M;
    logic          core_M_valid;
    logic [63:0]   core_len;
    logic          dig_valid;
    logic          dig_ready = 1'b0;
    logic [31:0]   dig_out;
    logic [LW-1:0] dig_len;
    logic          dig_ovf;
    logic          dig_err;

    // Core model state (written only by the model process).
    logic          model_rdy = 1'b0;
    logic [31:0]   model_dig = '0;
    logic          was_valid = 1'b0;
    int            lat = 0;
    int            bursts = 0;
    logic [31:0]   acc = '0;
    logic [7:0]    seen_b[$];
    logic [63:0]   seen_len[$];

    // Bench-driven controls.
    logic          core_on = 1'b1;
    logic          spur = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hash_msg_feeder #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_last         (in_last),
        .in_ready        (in_ready),
        .core_M          (core_M),
        .core_M_valid    (core_M_valid),
        .core_len        (core_len),
        .core_hash_ready (model_rdy | spur),
        .core_digest     (spur ? 32'hFFFF_FFFF : model_dig),
        .dig_valid       (dig_valid),
        .dig_ready       (dig_ready),
        .dig_out         (dig_out),
        .dig_len         (dig_len),
        .dig_ovf         (dig_ovf),
        .dig_err         (dig_err)
    );

    // Hash core model, sampled and driven on the falling edge.
    always @(negedge clk) begin
        model_rdy = 1'b0;
        if (!rst_n) begin
            was_valid = 1'b0;
            lat       = 0;
            acc       = '0;
        end else begin
            if (core_M_valid) begin
                if (!was_valid) begin
                    bursts++;
                    acc = '0;
                end
                acc = {acc[23:0], core_M};
                seen_b.push_back(core_M);
                seen_len.push_back(core_len);
            end else if (was_valid) begin
                lat = 3;
            end else if (lat > 0) begin
                lat--;
                if (lat == 0 && core_on) begin
                    model_rdy = 1'b1;
                    model_dig = acc ^ 32'h5A00_0000;
                end
            end
            was_valid = core_M_valid;
        end
    end

    // Present one byte for one cycle; ok reports whether it was accepted.
    task automatic push(input logic [7:0] d, input logic last, output logic ok);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        ok       = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    // Send n consecutive byte values starting at base.
    task automatic send_msg(input int n, input logic [7:0] base, input logic last);
        logic ok;
        int   tries;
        for (int i = 0; i < n; i++) begin
            ok    = 1'b0;
            tries = 0;
            while (!ok && tries < 50) begin
                push(8'(base + 8'(i)), last && (i == n - 1), ok);
                tries++;
            end
            if (!ok) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_byte_%0d in_ready got 0 exp 1", i);
            end
        end
    endtask

    task automatic wait_dig(output int k);
        k = 0;
        while (dig_valid !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic accept_dig();
        dig_ready = 1'b1;
        @(negedge clk);
        dig_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        n_tests++; if (core_M_valid !== 1'b0 || core_M !== 8'h00) begin n_fail++; $display("FAIL rst_core_M got %b/%h exp 0/00", core_M_valid, core_M); end
        n_tests++; if (core_len !== 64'd0) begin n_fail++; $display("FAIL rst_core_len got %0d exp 0", core_len); end
        n_tests++; if (dig_valid !== 1'b0 || dig_out !== 32'h0) begin n_fail++; $display("FAIL rst_dig got %b/%h exp 0/0", dig_valid, dig_out); end
        n_tests++; if (dig_len !== 4'd0 || dig_ovf !== 1'b0 || dig_err !== 1'b0) begin n_fail++; $display("FAIL rst_dig_flags got %0d/%b/%b exp 0/0/0", dig_len, dig_ovf, dig_err); end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_single_byte();
        int b0, k0, k;
        b0 = seen_b.size();
        k0 = bursts;
        send_msg(1, 8'h00, 1'b1);
        n_tests++; if (core_M_valid !== 1'b1 || core_M !== 8'h00 || core_len !== 64'd1) begin n_fail++; $display("FAIL single_first got %b/%h/%0d exp 1/00/1", core_M_valid, core_M, core_len); end
        @(negedge clk);
        n_tests++; if (core_M_valid !== 1'b0) begin n_fail++; $display("FAIL single_one_cycle got %b exp 0", core_M_valid); end
        wait_dig(k);
        n_tests++; if (dig_valid !== 1'b1) begin n_fail++; $display("FAIL single_dig_valid got %b exp 1", dig_valid); end
        n_tests++; if (seen_b.size() !== b0 + 1 || bursts !== k0 + 1) begin n_fail++; $display("FAIL single_bytes got %0d/%0d exp %0d/%0d", seen_b.size(), bursts, b0 + 1, k0 + 1); end
        n_tests++; if (dig_out !== 32'h5A00_0000 || dig_len !== 4'd1 || dig_err !== 1'b0) begin n_fail++; $display("FAIL single_result got %h/%0d/%b exp 5a000000/1/0", dig_out, dig_len, dig_err); end
        accept_dig();
    endtask

    task automatic test_abc_hold();
        int b0, k0, k;
        logic [7:0] e;
        b0 = seen_b.size();
        k0 = bursts;
        send_msg(3, 8'h61, 1'b1);
        n_tests++; if (core_M_valid !== 1'b1 || core_M !== 8'h61) begin n_fail++; $display("FAIL abc_first got %b/%h exp 1/61", core_M_valid, core_M); end
        wait_dig(k);
        n_tests++; if (dig_valid !== 1'b1) begin n_fail++; $display("FAIL abc_dig_valid got %b exp 1", dig_valid); end
        n_tests++; if (seen_b.size() !== b0 + 3 || bursts !== k0 + 1) begin n_fail++; $display("FAIL abc_burst got %0d/%0d exp %0d/%0d", seen_b.size(), bursts, b0 + 3, k0 + 1); end
        else begin
            for (int i = 0; i < 3; i++) begin
                e = 8'(8'h61 + 8'(i));
                n_tests++; if (seen_b[b0 + i] !== e || seen_len[b0 + i] !== 64'd3) begin n_fail++; $display("FAIL abc_byte_%0d got %h/%0d exp %h/3", i, seen_b[b0 + i], seen_len[b0 + i], e); end
            end
        end
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if (dig_valid !== 1'b1 || dig_out !== 32'h5A61_6263 || dig_len !== 4'd3 ||
                dig_ovf !== 1'b0 || dig_err !== 1'b0 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL abc_hold_%0d got v%b %h len%0d o%b e%b r%b exp v1 5a616263 len3 o0 e0 r0",
                         c, dig_valid, dig_out, dig_len, dig_ovf, dig_err, in_ready);
            end
            @(negedge clk);
        end
        accept_dig();
        n_tests++; if (dig_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL abc_release got v%b r%b exp v0 r1", dig_valid, in_ready); end
    endtask

    task automatic test_ignored_inputs();
        spur      = 1'b1;
        dig_ready = 1'b1;
        @(negedge clk);
        spur      = 1'b0;
        dig_ready = 1'b0;
        @(negedge clk);
        n_tests++; if (dig_valid !== 1'b0 || in_ready !== 1'b1 || core_M_valid !== 1'b0) begin n_fail++; $display("FAIL spurious got v%b r%b m%b exp v0 r1 m0", dig_valid, in_ready, core_M_valid); end
    endtask

    task automatic test_overflow();
        int b0, k, acc_n;
        logic ok;
        b0    = seen_b.size();
        acc_n = 0;
        for (int i = 0; i < 10; i++) begin
            push(8'(8'h10 + 8'(i)), 1'b0, ok);
            if (ok) acc_n++;
        end
        n_tests++; if (acc_n !== 8) begin n_fail++; $display("FAIL ovf_accepted got %0d exp 8", acc_n); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_in_ready got %b exp 0", in_ready); end
        wait_dig(k);
        n_tests++; if (seen_b.size() !== b0 + 8) begin n_fail++; $display("FAIL ovf_streamed got %0d exp %0d", seen_b.size() - b0, 8); end
        else if (seen_b[b0] !== 8'h10 || seen_b[b0 + 7] !== 8'h17 || seen_len[b0 + 7] !== 64'd8) begin
            n_fail++; $display("FAIL ovf_bytes got %h..%h len%0d exp 10..17 len8", seen_b[b0], seen_b[b0 + 7], seen_len[b0 + 7]);
        end
        n_tests++; if (dig_valid !== 1'b1 || dig_ovf !== 1'b1 || dig_len !== 4'd8 || dig_out !== 32'h4E15_1617) begin n_fail++; $display("FAIL ovf_result got v%b o%b len%0d %h exp v1 o1 len8 4e151617", dig_valid, dig_ovf, dig_len, dig_out); end
        accept_dig();
    endtask

    task automatic test_exact_depth();
        int k;
        send_msg(8, 8'h20, 1'b1);
        wait_dig(k);
        n_tests++; if (dig_valid !== 1'b1 || dig_ovf !== 1'b0 || dig_len !== 4'd8 || dig_out !== 32'h7E25_2627) begin n_fail++; $display("FAIL exact_result got v%b o%b len%0d %h exp v1 o0 len8 7e252627", dig_valid, dig_ovf, dig_len, dig_out); end
        accept_dig();
    endtask

    task automatic test_timeout();
        int k, g;
        core_on = 1'b0;
        send_msg(1, 8'hAA, 1'b1);
        g = 0;
        while (core_M_valid === 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        k = 0;
        while (dig_valid !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        n_tests++; if (k !== 16) begin n_fail++; $display("FAIL timeout_cycles got %0d exp 16", k); end
        n_tests++; if (dig_err !== 1'b1 || dig_out !== 32'h0 || dig_len !== 4'd1) begin n_fail++; $display("FAIL timeout_result got e%b %h len%0d exp e1 0 len1", dig_err, dig_out, dig_len); end
        accept_dig();
        core_on = 1'b1;
    endtask

    task automatic test_back_to_back();
        int k;
        dig_ready = 1'b1;
        send_msg(2, 8'h50, 1'b1);
        wait_dig(k);
        n_tests++; if (dig_valid !== 1'b1 || dig_out !== 32'h5A00_5051 || dig_err !== 1'b0 || dig_len !== 4'd2) begin n_fail++; $display("FAIL b2b_first got v%b %h e%b len%0d exp v1 5a005051 e0 len2", dig_valid, dig_out, dig_err, dig_len); end
        @(negedge clk);
        send_msg(1, 8'h52, 1'b1);
        wait_dig(k);
        n_tests++; if (dig_valid !== 1'b1 || dig_out !== 32'h5A00_0052 || dig_len !== 4'd1) begin n_fail++; $display("FAIL b2b_second got v%b %h len%0d exp v1 5a000052 len1", dig_valid, dig_out, dig_len); end
        @(negedge clk);
        dig_ready = 1'b0;
    endtask

    task automatic test_reset_mid_stream();
        int k, b0;
        send_msg(5, 8'h31, 1'b1);
        @(negedge clk);
        n_tests++; if (core_M_valid !== 1'b1 || core_M !== 8'h32 || core_len !== 64'd5) begin n_fail++; $display("FAIL mid_second_byte got %b/%h/%0d exp 1/32/5", core_M_valid, core_M, core_len); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (core_M_valid !== 1'b0 || core_M !== 8'h00 || core_len !== 64'd0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_core got %b/%h/%0d r%b exp 0/00/0 r0", core_M_valid, core_M, core_len, in_ready); end
        n_tests++; if (dig_valid !== 1'b0 || dig_out !== 32'h0 || dig_len !== 4'd0) begin n_fail++; $display("FAIL mid_reset_dig got v%b %h len%0d exp v0 0 len0", dig_valid, dig_out, dig_len); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        b0 = seen_b.size();
        send_msg(2, 8'h41, 1'b1);
        wait_dig(k);
        n_tests++; if (seen_b.size() !== b0 + 2) begin n_fail++; $display("FAIL mid_after_bytes got %0d exp 2", seen_b.size() - b0); end
        n_tests++; if (dig_valid !== 1'b1 || dig_out !== 32'h5A00_4142 || dig_len !== 4'd2 || dig_err !== 1'b0) begin n_fail++; $display("FAIL mid_after_result got v%b %h len%0d e%b exp v1 5a004142 len2 e0", dig_valid, dig_out, dig_len, dig_err); end
        accept_dig();
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_abc_hold();
        test_ignored_inputs();
        test_overflow();
        test_exact_depth();
        test_timeout();
        test_back_to_back();
        test_reset_mid_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hash_msg_feeder.md
HASH_MSG_FEEDER -- requirements
Module: hash_msg_feeder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64: message buffer capacity in bytes, a power of two, at least 2.
REQ-002 The block SHALL have parameter TIMEOUT, default 1024: maximum number of cycles spent waiting for core_hash_ready.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port in_data, input, 8 bits: host message byte.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 The block SHALL have port in_last, input, 1 bit: the current byte is the final byte of the message.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-009 The block SHALL have port core_M, output, 8 bits: byte to the hash core.
REQ-010 The block SHALL have port core_M_valid, output, 1 bit: byte-valid and start strobe to the hash core.
REQ-011 The block SHALL have port core_len, output, 64 bits: message length in bytes, zero-extended.
REQ-012 The block SHALL have port core_hash_ready, input, 1 bit: one-cycle done pulse from the hash core.
REQ-013 The block SHALL have port core_digest, input, 32 bits: digest from the hash core, valid while core_hash_ready is high.
REQ-014 The block SHALL have port dig_valid, output, 1 bit: result is available.
REQ-015 The block SHALL have port dig_ready, input, 1 bit: the consumer accepts the result.
REQ-016 The block SHALL have port dig_out, output, 32 bits: captured digest.
REQ-017 The block SHALL have port dig_len, output, clog2(DEPTH)+1 bits: number of bytes that were hashed.
REQ-018 The block SHALL have port dig_ovf, output, 1 bit: the message was truncated at DEPTH bytes.
REQ-019 The block SHALL have port dig_err, output, 1 bit: the core timed out.

Function
REQ-020 The block SHALL implement an FSM with states LOAD, STREAM, WAIT and OUT, and SHALL enter LOAD from reset.
REQ-021 LOAD: in_ready SHALL be 1 and core_M_valid SHALL be 0; each cycle with in_valid=1 SHALL write in_data to buf[wcnt] and increment wcnt.
REQ-022 LOAD: a handshake with in_last=1 SHALL end loading, set len to wcnt+1, and move the FSM to STREAM.
REQ-023 LOAD: if DEPTH bytes are accepted without in_last, the DEPTH-th byte SHALL act as last and set ovf=1.
REQ-024 While ovf=1, in_ready SHALL stay 0 until return to LOAD; bytes the host still presents are not consumed.
REQ-025 STREAM: for exactly len consecutive cycles, core_M_valid SHALL be 1 and core_M SHALL be buf[0], buf[1], ..., buf[len-1] in order; the first byte SHALL appear in the first STREAM cycle.
REQ-026 STREAM: core_len SHALL equal len for every STREAM cycle, and SHALL hold that value through WAIT.
REQ-027 The block SHALL present no gaps or stalls inside STREAM, because the core consumes one byte per cycle unconditionally.
REQ-028 After the last byte, the FSM SHALL move to WAIT, and core_M_valid SHALL be 0 in WAIT, OUT and LOAD so the core is never restarted spuriously.
REQ-029 WAIT: on core_hash_ready=1, the block SHALL capture core_digest into dig_out, set err=0, and move the FSM to OUT on the next edge.
REQ-030 WAIT: if TIMEOUT cycles elapse without core_hash_ready, the block SHALL set dig_out=0 and err=1, and move the FSM to OUT.
REQ-031 The WAIT cycle counter SHALL restart at 0 on every entry to WAIT.
REQ-032 OUT: dig_valid SHALL be 1, with dig_out, dig_len=len, dig_ovf and dig_err held stable until dig_valid&&dig_ready.
REQ-033 When the OUT handshake completes, the FSM SHALL return to LOAD with wcnt=0 and ovf=0.
REQ-034 dig_ready SHALL be ignored in every state except OUT.
REQ-035 core_hash_ready arriving outside WAIT SHALL be ignored.
REQ-036 A message SHALL never be streamed with length 0; len is always in 1..DEPTH.
REQ-037 A simultaneous in_valid&&in_last on the byte that reaches DEPTH SHALL be treated as a normal last, with ovf=0.
REQ-038 Buffer read timing is implementation choice (combinational, or registered with prefetch), provided that REQ-025 timing holds at the ports.

Reset
REQ-039 While rst_n=0, the FSM SHALL be in LOAD, with wcnt=0, len=0, ovf=0, err=0 and the timeout counter at 0.
REQ-040 While rst_n=0, in_ready SHALL be 0.
REQ-041 While rst_n=0, core_M=0, core_M_valid=0 and core_len=0.
REQ-042 While rst_n=0, dig_valid=0, dig_out=0, dig_len=0, dig_ovf=0 and dig_err=0.
REQ-043 After reset deasserts, in_ready SHALL be 1 from the first rising edge onward.
REQ-044 Buffer contents SHALL not require reset.
REQ-045 Reset mid-STREAM or mid-WAIT SHALL abort the message with no output result; the hash core, reset by the same rst_n, is thereby also idle.

Verification
REQ-046 Reset, then send the single byte 0x00 with in_last=1 -> core_M_valid is high exactly 1 cycle with core_M=0x00 and core_len=1; the digest appears with dig_len=1.
REQ-047 Send 0x61, 0x62, 0x63 (last on 0x63) with an attached core -> core_M is 0x61, 0x62, 0x63 on 3 back-to-back cycles; dig_out equals the core digest; dig_err=0.
REQ-048 Hold dig_ready=0 for 5 cycles while in OUT -> dig_valid and all dig_* outputs are stable; in_ready=0 throughout; LOAD is re-entered the cycle after the handshake.
REQ-049 With DEPTH=4, send 6 bytes and no last -> 4 bytes are accepted; in_ready stays 0 afterwards; 4 bytes are streamed; dig_ovf=1 and dig_len=4.
REQ-050 With TIMEOUT=16 and core_hash_ready tied to 0 -> dig_valid rises 16 cycles after WAIT entry with dig_err=1 and dig_out=0.
REQ-051 Assert rst_n=0 on the 2nd byte of a 5-byte STREAM -> all outputs take their reset values immediately; after release, a new 2-byte message hashes correctly.
